// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: sequences the core reset, bounds run length, detects halt and hashes write-back traffic.
// Optional PC stall watchdog enabled by defining CPU_RUN_CTRL_WDOG_EN.
module cpu_run_ctrl #(
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 16,
  parameter int RST_CYCLES  = 2,
  parameter int MAX_CYCLES  = 1000,
  parameter int PC_W        = 32,
  parameter int STALL_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_req,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
`ifdef CPU_RUN_CTRL_WDOG_EN
  input  logic [PC_W-1:0]   pc,
  output logic              stalled,
`endif
  output logic              cpu_rst,
  output logic              running,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [DATA_W-1:0] signature
);
  localparam int RST_N = RST_CYCLES < 1 ? 1 : RST_CYCLES;
  typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;
  state_t            state_q, state_d;
  logic [31:0]       rcnt_q, rcnt_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d, ret_q, ret_d, cyc_inc;
  logic [DATA_W-1:0] sig_q, sig_d;
  logic              cpu_rst_q, cpu_rst_d, running_q, running_d;
  logic              done_q, done_d, timeout_q, timeout_d;
  logic              launch, run, hit_max, hit_stall, ending;
  assign run     = state_q == RUN;
  assign launch  = state_d == RESET && state_q != RESET;
  assign ending  = run && state_d == DONE;
  assign cyc_inc = cyc_q + 1'b1;
  assign hit_max = cyc_inc == CNT_W'(MAX_CYCLES);
`ifdef CPU_RUN_CTRL_WDOG_EN
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     stall_q, stall_d, stall_inc;
  logic            stalled_q, stalled_d;
  // cyc_q is zero only in the first RUN cycle, which always counts as a PC change
  assign stall_inc = (cyc_q == '0 || pc != pc_q) ? 32'd0 : stall_q + 32'd1;
  assign hit_stall = stall_inc == 32'(STALL_LIMIT);
  assign stalled   = stalled_q;
  always_comb begin
    pc_d      = run ? pc : pc_q;
    stall_d   = launch ? 32'd0 : run ? stall_inc : stall_q;
    stalled_d = launch ? 1'b0 : ending ? !halt_req && hit_stall : stalled_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= '0;
      stall_q   <= '0;
      stalled_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      stall_q   <= stall_d;
      stalled_q <= stalled_d;
    end
  end
`else
  assign hit_stall = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rcnt_q    <= '0;
      cyc_q     <= '0;
      ret_q     <= '0;
      sig_q     <= '0;
      cpu_rst_q <= 1'b1;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      cyc_q     <= cyc_d;
      ret_q     <= ret_d;
      sig_q     <= sig_d;
      cpu_rst_q <= cpu_rst_d;
      running_q <= running_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = RESET;
      RESET:      if (rcnt_q == 32'd1) state_d = RUN;
      RUN:        if (halt_req || hit_stall || hit_max) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end
  always_comb begin
    cpu_rst_d = state_d != RUN;
    running_d = state_d == RUN;
    done_d    = state_d == DONE;
    timeout_d = launch ? 1'b0 : ending ? !halt_req && !hit_stall : timeout_q;
    rcnt_d    = launch ? 32'(RST_N) : state_q == RESET ? rcnt_q - 32'd1 : rcnt_q;
    cyc_d     = launch ? '0 : run ? cyc_inc : cyc_q;
    ret_d     = launch ? '0 : run && wb_en ? ret_q + 1'b1 : ret_q;
    sig_d     = launch ? '0 : run && wb_en
              ? {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ wb_data ^ DATA_W'(wb_addr) : sig_q;
  end
  assign cpu_rst     = cpu_rst_q;
  assign running     = running_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_cnt   = cyc_q;
  assign retired_cnt = ret_q;
  assign signature   = sig_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: randomized runs of cpu_run_ctrl checked against a per-run arithmetic model.
module tb_cpu_run_ctrl;
  localparam int MAXC = 10;
  logic        clk = 0, rst = 1, start = 0, halt_req = 0, wb_en = 0;
  logic [4:0]  wb_addr = 0;
  logic [31:0] wb_data = 0;
  logic        cpu_rst, running, done, timeout;
  logic [15:0] cycle_cnt, retired_cnt;
  logic [31:0] signature;
  int checks = 0, errors = 0;
  logic [31:0] dd [3] = '{32'h5, 32'h10, 32'h0};
  logic [4:0]  da [3] = '{5'd1, 5'd2, 5'd0};
  logic        de [3] = '{1'b1, 1'b1, 1'b0};
`ifdef CPU_RUN_CTRL_WDOG_EN
  logic [31:0] pc = 0;
  logic        stalled;
`endif
  cpu_run_ctrl #(.DATA_W(32), .CNT_W(16), .RST_CYCLES(2), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data),
`ifdef CPU_RUN_CTRL_WDOG_EN
    .pc(pc), .stalled(stalled),
`endif
    .cpu_rst(cpu_rst), .running(running), .done(done), .timeout(timeout),
    .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt), .signature(signature));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_cleared(input string tag);
    chk({tag, "_cpu_rst"}, cpu_rst, 1);
    chk({tag, "_running"}, running, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_cyc"}, cycle_cnt, 0);
    chk({tag, "_ret"}, retired_cnt, 0);
    chk({tag, "_sig"}, signature, 0);
  endtask
  // halt_at=0: no halt; rst_at>0: reset pulsed in that RUN cycle; dir: use the fixed write table
  task automatic do_run(input int halt_at, input int rst_at, input bit dir, input bit poke);
    logic [31:0] sig = 0;
    int ret = 0, last = 0;
    @(negedge clk); start = 1;
    @(posedge clk); #1 chk_cleared("launch");
    @(negedge clk); start = poke;
    @(posedge clk); #1 chk("rst_hold", cpu_rst, 1);
    chk("rst_hold_run", running, 0);
    @(negedge clk); start = 0;
    @(posedge clk); #1 chk("entry_cpu_rst", cpu_rst, 0);
    chk("entry_running", running, 1);
    chk("entry_cyc", cycle_cnt, 0);
    for (int k = 1; k <= MAXC; k++) begin
      @(negedge clk);
      if (dir) begin
        wb_en = k <= 3 ? de[k-1] : 1'b0;
        wb_addr = k <= 3 ? da[k-1] : 5'd0;
        wb_data = k <= 3 ? dd[k-1] : 32'd0;
      end else begin
        wb_en = (k == MAXC) ? 1'b1 : 1'($urandom_range(0, 1));
        wb_addr = 5'($urandom);
        wb_data = $urandom;
      end
      halt_req = k == halt_at;
      start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      rst = k == rst_at;
`ifdef CPU_RUN_CTRL_WDOG_EN
      pc = 32'(k * 4);
`endif
      @(posedge clk); #1
      if (k == rst_at) begin
        rst = 0;
        chk_cleared("midrst");
        @(negedge clk); start = 0; wb_en = 0; halt_req = 0;
        @(posedge clk); #1 chk_cleared("midrst_idle");
        return;
      end
      if (wb_en) begin
        ret++;
        sig = {sig[30:0], sig[31]} ^ wb_data ^ {27'd0, wb_addr};
      end
      chk("cyc", cycle_cnt, k);
      chk("ret", retired_cnt, ret);
      chk("sig", signature, sig);
      last = k;
      if (k == halt_at || k == MAXC) break;
      chk("run_running", running, 1);
      chk("run_done", done, 0);
    end
    chk("end_done", done, 1);
    chk("end_timeout", timeout, halt_at != last);
    chk("end_cpu_rst", cpu_rst, 1);
    chk("end_running", running, 0);
`ifdef CPU_RUN_CTRL_WDOG_EN
    chk("end_stalled", stalled, 0);
`endif
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      start = 0; wb_en = 1'($urandom_range(0, 1)); halt_req = 1'($urandom_range(0, 1));
      wb_data = $urandom;
      @(posedge clk); #1
      chk("hold_done", done, 1);
      chk("hold_timeout", timeout, halt_at != last);
      chk("hold_cyc", cycle_cnt, last);
      chk("hold_ret", retired_cnt, ret);
      chk("hold_sig", signature, sig);
    end
    @(negedge clk); wb_en = 0; halt_req = 0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 chk_cleared("reset");
    @(negedge clk); rst = 0;
    repeat (2) @(posedge clk);
    #1 chk_cleared("idle");
    do_run(3, 0, 1, 0);
    chk("tp_sig", signature, 32'h1A);
    chk("tp_ret", retired_cnt, 2);
    chk("tp_cyc", cycle_cnt, 3);
    do_run(0, 0, 0, 0);
    do_run(0, 0, 0, 1);
    do_run(MAXC, 0, 0, 0);
    do_run(0, 5, 0, 1);
    do_run(1, 0, 0, 0);
    for (int r = 0; r < 20; r++)
      do_run($urandom_range(0, MAXC), ($urandom_range(0, 3) == 0) ? $urandom_range(1, MAXC) : 0,
             0, 1'($urandom_range(0, 1)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
